credit_tx: RTL and testbench

//  Credit-based transmitter: the sending end of the credit link whose receiver is a

---
 rtl/credit_tx.sv | 91 +++++++++
 tb/tb_credit_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/credit_tx.sv
// Credit-based transmitter: 2-entry in-order buffer feeding a credit-gated write strobe.
// One credit is spent per word sent and one is regained per cr_ret pulse.
module credit_tx #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CREDITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_we,
    input  logic             cr_ret,
    output logic [3:0]       credit_cnt,
    output logic             credit_err,
    output logic             idle
);

    localparam logic [3:0] CredMax = 4'(CREDITS);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_we_q, tx_we_d;
    logic [3:0]       credit_q, credit_d;
    logic             err_q, err_d;
    logic             push, send;

    always_comb begin
        push       = in_valid & in_ready_q;
        send       = (buf_cnt_q != 2'd0) && (credit_q != 4'd0);
        buf_cnt_d  = buf_cnt_q + 2'(push) - 2'(send);
        // Registered ready: depends only on buffer occupancy, never on cr_ret.
        in_ready_d = (buf_cnt_d < 2'd2);
        tx_we_d    = send;
        tx_data_d  = send ? mem_q[rd_ptr_q] : tx_data_q;
        credit_d   = credit_q;
        err_d      = err_q;
        if (send && !cr_ret) begin
            credit_d = credit_q - 4'd1;
        end else if (cr_ret && !send) begin
            if (credit_q == CredMax) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_cnt_q  <= 2'd0;
            in_ready_q <= 1'b1;
            tx_data_q  <= '0;
            tx_we_q    <= 1'b0;
            credit_q   <= CredMax;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (send) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            buf_cnt_q  <= buf_cnt_d;
            in_ready_q <= in_ready_d;
            tx_data_q  <= tx_data_d;
            tx_we_q    <= tx_we_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        in_ready   = in_ready_q;
        tx_data    = tx_data_q;
        tx_we      = tx_we_q;
        credit_cnt = credit_q;
        credit_err = err_q;
        idle       = (credit_q == CredMax) && (buf_cnt_q == 2'd0) && !tx_we_q;
    end

endmodule

// File: tb/tb_credit_tx.sv
// Self-checking bench for credit_tx: directed scenarios plus random traffic checked against a
// queue/credit-count reference model.
module tb_credit_tx;

    localparam int CRED = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] tx_data;
    logic        tx_we;
    logic        cr_ret = 1'b0;
    logic [3:0]  credit_cnt;
    logic        credit_err;
    logic        idle;

    credit_tx #(.WIDTH(32), .CREDITS(CRED)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_we      (tx_we),
        .cr_ret     (cr_ret),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: words accepted but not yet sent, credits held, sticky error.
    logic [31:0] q[$];
    int          m_cred;
    bit          m_err;
    bit          m_we;
    logic [31:0] m_last;
    int          rx_fill;
    int          delivered;
    int          dut_pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cred  = CRED;
        m_err   = 1'b0;
        m_we    = 1'b0;
        m_last  = '0;
        rx_fill = 0;
    endtask

    task automatic check_state();
        check("credit_cnt", {28'd0, credit_cnt}, 32'(m_cred));
        check("credit_err", {31'd0, credit_err}, {31'd0, m_err});
        check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        check("idle", {31'd0, idle}, {31'd0, (m_cred == CRED) && (q.size() == 0) && !m_we});
    endtask

    // One clock: drive inputs, advance, then compare everything against the model.
    task automatic step(input bit v, input logic [31:0] d, input bit ret, output bit acc);
        int pb, pc;
        in_valid = v;
        in_data  = d;
        cr_ret   = ret;
        pb  = q.size();
        pc  = m_cred;
        acc = v && (pb < 2);
        @(posedge clk);
        #1;
        m_we = (pb != 0) && (pc != 0);
        check("tx_we", {31'd0, tx_we}, {31'd0, m_we});
        if (tx_we) dut_pulses++;
        if (m_we) begin
            m_last = q.pop_front();
            delivered++;
            rx_fill++;
        end
        check("tx_data", tx_data, m_last);
        if (acc) q.push_back(d);
        if (m_we && !ret) m_cred--;
        else if (ret && !m_we) begin
            if (m_cred == CRED) m_err = 1'b1;
            else m_cred++;
        end
        check_state();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        cr_ret   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Hold a word until accepted, within a cycle budget.
    task automatic push_word(input logic [31:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            step(1'b1, d, 1'b0, acc);
            n++;
        end
        check("push_accepted", {31'd0, acc}, 32'd1);
    endtask

    initial begin
        bit          acc, pend, ret, h1, h2;
        logic [31:0] pdata;
        int          cyc;

        // 1: reset state
        model_reset();
        do_reset();
        #1;
        check_state();
        check("reset_tx_we", {31'd0, tx_we}, 32'd0);

        // 2: six words, no credit returns
        dut_pulses = 0;
        for (int i = 0; i < 6; i++) push_word(32'h11 + 32'(i));
        repeat (3) step(1'b0, '0, 1'b0, acc);
        check("t2_pulses", 32'(dut_pulses), 32'd4);
        check("t2_credit", {28'd0, credit_cnt}, 32'd0);
        check("t2_ready", {31'd0, in_ready}, 32'd0);
        check("t2_buf", 32'(q.size()), 32'd2);

        // 3: one credit returned at edge E, word 0x15 out after E+1
        step(1'b0, '0, 1'b1, acc);
        check("t3_we_at_e", {31'd0, tx_we}, 32'd0);
        step(1'b0, '0, 1'b0, acc);
        check("t3_we", {31'd0, tx_we}, 32'd1);
        check("t3_data", tx_data, 32'h15);
        check("t3_credit", {28'd0, credit_cnt}, 32'd0);

        // 6: asynchronous reset while tx_we is high and 0x16 is still buffered
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("t6_we_async", {31'd0, tx_we}, 32'd0);
        check_state();
        @(negedge clk);
        reset_n = 1'b1;
        push_word(32'h99);
        repeat (2) step(1'b0, '0, 1'b0, acc);
        check("t6_new_word", m_last, 32'h99);
        check("t6_data", tx_data, 32'h99);

        // 4: stream 100 words with credits returned two cycles after each tx_we
        do_reset();
        delivered = 0;
        pend = 1'b0;
        h1 = 1'b0;
        h2 = 1'b0;
        cyc = 0;
        for (int sent = 0; delivered < 100 && cyc < 105; cyc++) begin
            if (!pend && sent < 100) begin
                pend  = 1'b1;
                pdata = $urandom;
                sent++;
            end
            step(pend, pdata, h2, acc);
            h2 = h1;
            h1 = tx_we;
            if (acc) pend = 1'b0;
        end
        check("t4_delivered", 32'(delivered), 32'd100);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, h2, acc);
            h2 = h1;
            h1 = tx_we;
        end
        check("t4_idle", {31'd0, idle}, 32'd1);
        check("t4_credit", {28'd0, credit_cnt}, 32'd4);
        check("t4_err", {31'd0, credit_err}, 32'd0);

        // 5: spurious credit while idle, then normal traffic with a receiver model
        step(1'b0, '0, 1'b1, acc);
        check("t5_err", {31'd0, credit_err}, 32'd1);
        check("t5_credit", {28'd0, credit_cnt}, 32'd4);
        rx_fill = 0;
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom % 4) != 0) begin
                pend  = 1'b1;
                pdata = $urandom;
            end
            ret = (rx_fill > 0) && (($urandom % 2) == 1);
            step(pend, pdata, ret, acc);
            if (ret) rx_fill--;
            if (acc) pend = 1'b0;
        end
        check("t5_err_sticky", {31'd0, credit_err}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
